// File: rtl/dmem_access_ctrl_if.sv
// Bundles the core port, the debug/loader port and the data-memory bus of
// dmem_access_ctrl. The controller side uses the slave modport; requesters and
// the memory model sit on the master side.
interface dmem_access_ctrl_if;
    // Core load/store port
    logic        c_req;
    logic        c_we;
    logic [2:0]  c_func3;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_ack;
    logic [31:0] c_rdata;
    logic        c_err;
    // Debug/loader port
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_func3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    // Word-wide data memory (async read, sync write)
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Handshake: a requester raises req with we/func3/addr/wdata and holds them
    // stable until it sees a one-cycle ack; rdata/err are valid only while ack=1.
    // A req still high in the cycle after ack is taken as a new request.
    modport slave (
        input  c_req, c_we, c_func3, c_addr, c_wdata,
        output c_ack, c_rdata, c_err,
        input  d_req, d_we, d_func3, d_addr, d_wdata,
        output d_ack, d_rdata, d_err,
        output mem_read, mem_write, mem_func3, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output c_req, c_we, c_func3, c_addr, c_wdata,
        input  c_ack, c_rdata, c_err,
        output d_req, d_we, d_func3, d_addr, d_wdata,
        input  d_ack, d_rdata, d_err,
        input  mem_read, mem_write, mem_func3, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: arbitrates core and debug ports, performs
// sub-word load extraction/extension and sub-word store read-modify-write,
// and rejects illegal or misaligned accesses without touching memory.
module dmem_access_ctrl #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_access_ctrl_if.slave    bus,
    output logic [1:0]           o_dbg_state
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_MERGE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]  r_state;
    logic        r_last_dbg;   // 1 = debug port won the last grant
    logic        r_port_dbg;   // port owning the transaction in flight
    logic        r_we;
    logic [2:0]  r_func3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_any_req;
    logic        w_grant_dbg;
    logic        w_sel_we;
    logic [2:0]  w_sel_func3;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_illegal;
    logic        w_misalign;
    logic [4:0]  w_shift;
    logic [31:0] w_lane;
    logic [31:0] w_load_ext;
    logic [31:0] w_mask;
    logic [31:0] w_merged;
    logic        w_is_sw;
    logic        w_done;

    // Arbitration and legality check of the request presented in IDLE
    always_comb begin
        w_any_req = bus.c_req | bus.d_req;
        if (bus.c_req && bus.d_req) begin
            w_grant_dbg = ROUND_ROBIN ? ~r_last_dbg : 1'b0;
        end else begin
            w_grant_dbg = bus.d_req;
        end
        w_sel_we    = w_grant_dbg ? bus.d_we    : bus.c_we;
        w_sel_func3 = w_grant_dbg ? bus.d_func3 : bus.c_func3;
        w_sel_addr  = w_grant_dbg ? bus.d_addr  : bus.c_addr;
        w_sel_wdata = w_grant_dbg ? bus.d_wdata : bus.c_wdata;
        if (w_sel_we) begin
            w_illegal = (w_sel_func3 > 3'd2);
        end else begin
            w_illegal = (w_sel_func3 == 3'd3) || (w_sel_func3 == 3'd6) ||
                        (w_sel_func3 == 3'd7);
        end
        w_misalign = ((w_sel_func3[1:0] == 2'b01) && w_sel_addr[0]) ||
                     ((w_sel_func3[1:0] == 2'b10) && (w_sel_addr[1:0] != 2'b00));
    end

    // Little-endian lane extraction, extension and store-lane merge
    always_comb begin
        w_shift = {r_addr[1:0], 3'b000};
        w_lane  = bus.mem_rdata >> w_shift;
        case (r_func3)
            3'b000:  w_load_ext = {{24{w_lane[7]}},  w_lane[7:0]};
            3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load_ext = {24'h0, w_lane[7:0]};
            3'b101:  w_load_ext = {16'h0, w_lane[15:0]};
            default: w_load_ext = w_lane;   // word loads are aligned, shift is 0
        endcase
        w_mask   = (r_func3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_shift;
        w_merged = (r_buf & ~w_mask) | ((r_wdata << w_shift) & w_mask);
        w_is_sw  = r_we && (r_func3[1:0] == 2'b10);
    end

    // Sequencer: IDLE -> ACCESS [-> MERGE] -> DONE, or IDLE -> DONE on error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last_dbg <= 1'b1;
            r_port_dbg <= 1'b0;
            r_we       <= 1'b0;
            r_func3    <= 3'b000;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_buf      <= 32'h0;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_port_dbg <= w_grant_dbg;
                        r_last_dbg <= w_grant_dbg;
                        r_we       <= w_sel_we;
                        r_func3    <= w_sel_func3;
                        r_addr     <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        r_rdata    <= 32'h0;
                        r_err      <= w_illegal | w_misalign;
                        r_state    <= (w_illegal | w_misalign) ? S_DONE : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!r_we) begin
                        r_rdata <= w_load_ext;
                        r_state <= S_DONE;
                    end else if (w_is_sw) begin
                        r_state <= S_DONE;
                    end else begin
                        r_buf   <= bus.mem_rdata;
                        r_state <= S_MERGE;
                    end
                end
                S_MERGE: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Port responses and memory strobes; strobes are held off while reset is
    // asserted so an aborted MERGE never commits its write.
    always_comb begin
        w_done        = (r_state == S_DONE);
        bus.c_ack     = w_done & ~r_port_dbg;
        bus.d_ack     = w_done &  r_port_dbg;
        bus.c_rdata   = bus.c_ack ? r_rdata : 32'h0;
        bus.d_rdata   = bus.d_ack ? r_rdata : 32'h0;
        bus.c_err     = bus.c_ack & r_err;
        bus.d_err     = bus.d_ack & r_err;
        bus.mem_read  = rst_n && (r_state == S_ACCESS) && !w_is_sw;
        bus.mem_write = rst_n && (((r_state == S_ACCESS) && w_is_sw) ||
                                  (r_state == S_MERGE));
        bus.mem_func3 = 3'b010;
        bus.mem_addr  = {r_addr[31:2], 2'b00};
        if (r_state == S_MERGE) begin
            bus.mem_wdata = w_merged;
        end else if ((r_state == S_ACCESS) && w_is_sw) begin
            bus.mem_wdata = r_wdata;
        end else begin
            bus.mem_wdata = 32'h0;
        end
        o_dbg_state = r_state;
    end
endmodule
